adder_calc_ctrl: RTL and testbench

Sequencing controller for the switch-operand 4-bit adder and its 4-digit seven-segment display. It debounces the `calculate` button and latches both operands on a clean press. It then registers the 5-bit sum and drives the digit-scan strobes, including the 'E' overflow indication. Its `digit`/`an`/`led` outputs feed the existing 2-bit segment decoder and board LEDs directly.

---
 rtl/adder_calc_pkg.sv | 19 +
 rtl/btn_debounce.sv | 45 ++++
 rtl/adder_calc_ctrl.sv | 125 ++++++++++++
 tb/tb_adder_calc_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_calc_pkg.sv
// Shared types and constants for the switch-operand adder controller
// and its seven-segment display scan.
package adder_calc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      ADD,
      SHOW,
      ERR
   } state_t;

   localparam logic [1:0] DIG_ZERO = 2'd0;
   localparam logic [1:0] DIG_ONE  = 2'd1;
   localparam logic [1:0] DIG_ERR  = 2'd2;

   localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for a raw,
// bouncy push button.
module btn_debounce #(
   parameter int DB_CNT_MAX = 250000
) (
   input  logic clk,
   input  logic clr,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(DB_CNT_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT_MAX - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // Any cycle where the synced level agrees with the output restarts the
   // count, so only DB_CNT_MAX consecutive disagreeing cycles flip it.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (sync2 == dout) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt  <= '0;
         dout <= sync2;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/adder_calc_ctrl.sv
// Sequencing controller: debounced calculate press, operand capture,
// 5-bit sum register and seven-segment digit scan with 'E' on overflow.
module adder_calc_ctrl
   import adder_calc_pkg::*;
#(
   parameter int DB_CNT_MAX = 250000,
   parameter int SCAN_SHIFT = 14
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] num1,
   input  logic [3:0] num2,
   input  logic       calculate,
   output logic [3:0] an,
   output logic [1:0] digit,
   output logic [4:0] led,
   output logic       ovf
);

   logic                  db_level;
   logic                  db_prev;
   logic                  press;
   state_t                state;
   state_t                state_next;
   logic [3:0]            a_q;
   logic [3:0]            b_q;
   logic [4:0]            sum_q;
   logic [4:0]            sum_comb;
   logic [SCAN_SHIFT+1:0] scan_cnt;
   logic [1:0]            scan_digit;

   btn_debounce #(
      .DB_CNT_MAX(DB_CNT_MAX)
   ) u_debounce (
      .clk (clk),
      .clr (clr),
      .din (calculate),
      .dout(db_level)
   );

   // Registered rising edge of the debounced level: one pulse per press.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         db_prev <= 1'b0;
         press   <= 1'b0;
      end else begin
         db_prev <= db_level;
         press   <= db_level & ~db_prev;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   assign sum_comb = {1'b0, a_q} + {1'b0, b_q};

   // CAPTURE and ADD ignore press, so a press while busy is simply lost.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, SHOW, ERR: begin
            if (press) begin
               state_next = CAPTURE;
            end
         end
         CAPTURE: state_next = ADD;
         ADD:     state_next = sum_comb[4] ? ERR : SHOW;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         a_q   <= 4'd0;
         b_q   <= 4'd0;
         sum_q <= 5'd0;
      end else begin
         if (state == CAPTURE) begin
            a_q <= num1;
            b_q <= num2;
         end
         if (state == ADD) begin
            sum_q <= sum_comb;
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         scan_cnt <= '0;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign scan_digit = scan_cnt[SCAN_SHIFT+1:SCAN_SHIFT];

   always_comb begin
      an    = AN_OFF;
      digit = DIG_ZERO;
      case (state)
         SHOW: begin
            an    = ~(4'b0001 << scan_digit);
            digit = sum_q[scan_digit] ? DIG_ONE : DIG_ZERO;
         end
         ERR: begin
            an    = 4'b1110;
            digit = DIG_ERR;
         end
         default: begin
            an    = AN_OFF;
            digit = DIG_ZERO;
         end
      endcase
   end

   assign led = sum_q;
   assign ovf = sum_q[4];

endmodule

// File: tb/tb_adder_calc_ctrl.sv
// Directed scoreboard bench for adder_calc_ctrl with a short debounce and
// fast scan so every path completes in a few hundred cycles.
module tb_adder_calc_ctrl;

   localparam int DB_CNT_MAX = 4;
   localparam int SCAN_SHIFT = 2;

   typedef struct {
      logic [4:0] led;
      logic       ovf;
   } expected_t;

   logic       clk;
   logic       clr;
   logic [3:0] num1;
   logic [3:0] num2;
   logic       calculate;
   logic [3:0] an;
   logic [1:0] digit;
   logic [4:0] led;
   logic       ovf;

   int         checks;
   int         errors;
   logic [4:0] last_led;
   logic [3:0] scan_model;
   expected_t  expected_q[$];

   adder_calc_ctrl #(
      .DB_CNT_MAX(DB_CNT_MAX),
      .SCAN_SHIFT(SCAN_SHIFT)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .num1     (num1),
      .num2     (num2),
      .calculate(calculate),
      .an       (an),
      .digit    (digit),
      .led      (led),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference scan position, counting clock edges since the last reset.
   always @(posedge clk or posedge clr) begin
      if (clr) begin
         scan_model <= 4'd0;
      end else begin
         scan_model <= scan_model + 4'd1;
      end
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_an"}, {4'd0, an}, 8'h0F);
      checkOutput({tag, "_digit"}, {6'd0, digit}, 8'h00);
      checkOutput({tag, "_led"}, {3'd0, led}, 8'h00);
      checkOutput({tag, "_ovf"}, {7'd0, ovf}, 8'h00);
   endtask

   task automatic checkScan(input logic [4:0] sum, input int cycles);
      logic [1:0] d;
      logic [3:0] an_exp;
      logic [1:0] dig_exp;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         d       = scan_model[3:2];
         an_exp  = ~(4'b0001 << d);
         dig_exp = {1'b0, sum[d]};
         checkOutput("scan_an", {4'd0, an}, {4'd0, an_exp});
         checkOutput("scan_digit", {6'd0, digit}, {6'd0, dig_exp});
      end
   endtask

   task automatic checkErr(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         checkOutput("err_an", {4'd0, an}, 8'h0E);
         checkOutput("err_digit", {6'd0, digit}, 8'h02);
      end
   endtask

   // Clean press with the given operands; optionally forces an extra press
   // pulse while the controller is in ADD.
   task automatic applyStimulus(input logic [3:0] n1, input logic [3:0] n2, input bit inject);
      expected_t e;
      e.led = {1'b0, n1} + {1'b0, n2};
      e.ovf = e.led[4];
      expected_q.push_back(e);
      num1      = n1;
      num2      = n2;
      calculate = 1'b1;
      repeat (9) @(negedge clk);
      checkOutput("pre_led", {3'd0, led}, {3'd0, last_led});
      checkOutput("busy_an", {4'd0, an}, 8'h0F);
      if (inject) force dut.press = 1'b1;
      @(negedge clk);
      if (inject) force dut.press = 1'b0;
      e = expected_q.pop_front();
      checkOutput("sum_led", {3'd0, led}, {3'd0, e.led});
      checkOutput("sum_ovf", {7'd0, ovf}, {7'd0, e.ovf});
      last_led = e.led;
      @(negedge clk);
      if (inject) release dut.press;
      calculate = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      expected_t e;
      checks    = 0;
      errors    = 0;
      last_led  = 5'd0;
      clr       = 1'b1;
      calculate = 1'b1;
      num1      = 4'd0;
      num2      = 4'd0;

      // Reset with the button held, then the held button yields one press.
      repeat (3) @(negedge clk);
      checkReset("reset");
      e.led = 5'd0;
      e.ovf = 1'b0;
      expected_q.push_back(e);
      clr = 1'b0;
      repeat (9) @(negedge clk);
      checkOutput("held_idle_an", {4'd0, an}, 8'h0F);
      @(negedge clk);
      e = expected_q.pop_front();
      checkOutput("held_led", {3'd0, led}, {3'd0, e.led});
      checkOutput("held_ovf", {7'd0, ovf}, {7'd0, e.ovf});
      checkScan(5'd0, 4);
      calculate = 1'b0;
      repeat (8) @(negedge clk);

      // Bounce shorter than the debounce window never presses.
      clr = 1'b1;
      @(negedge clk);
      clr      = 1'b0;
      last_led = 5'd0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         calculate = ~calculate;
         repeat (2) @(negedge clk);
      end
      calculate = 1'b0;
      repeat (20) @(negedge clk);
      checkReset("bounce");

      // Normal add and full scan.
      applyStimulus(4'd5, 4'd7, 1'b0);
      checkScan(5'b01100, 16);

      // Switch changes while showing leave the result alone.
      num1 = 4'd15;
      num2 = 4'd15;
      repeat (5) @(negedge clk);
      checkOutput("switch_led", {3'd0, led}, 8'h0C);
      checkOutput("switch_ovf", {7'd0, ovf}, 8'h00);
      checkScan(5'b01100, 4);

      // Overflow shows 'E' across a full scan wrap.
      applyStimulus(4'd9, 4'd8, 1'b0);
      checkErr(20);

      // Recovery from ERR, with an extra press pulse forced during ADD.
      applyStimulus(4'd9, 4'd1, 1'b1);
      checkScan(5'b01010, 8);

      // Asynchronous reset in the middle of a SHOW scan.
      repeat (3) @(negedge clk);
      #2 clr = 1'b1;
      #1 checkReset("midreset");
      @(negedge clk);
      clr      = 1'b0;
      last_led = 5'd0;
      applyStimulus(4'd5, 4'd7, 1'b0);
      checkScan(5'b01100, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

endmodule
